// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared constants and types for the serial sequence detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int                             DEFAULT_PATTERN_LEN = 3;
  localparam logic [DEFAULT_PATTERN_LEN-1:0] DEFAULT_PATTERN     = 3'b101;
  localparam int                             MATCH_CNT_W         = 16;

  typedef logic [MATCH_CNT_W-1:0] match_cnt_t;

  localparam match_cnt_t MATCH_CNT_MAX = '1;

endpackage : seq_det_pkg

`default_nettype wire

// File: rtl/seq_det_history.sv
// ============================================================================
// Module   : seq_det_history
// Brief    : Bit history shift register with saturating fill count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PATTERN_LEN = DEFAULT_PATTERN_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_bit_i,
  input  logic                   restart_i,
  output logic [PATTERN_LEN-1:0] candidate_o,
  output logic                   valid_o
);

  localparam int                HIST_W   = PATTERN_LEN - 1;
  localparam int                FILL_W   = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign candidate_o = {hist_q, in_bit_i};
  assign valid_o     = (fill_q == FILL_MAX);

  // The shift continues after a restart; only the fill count marks it stale.
  always_comb begin
    hist_d = candidate_o[HIST_W-1:0];
    fill_d = fill_q;
    if (restart_i) begin
      fill_d = '0;
    end else if (fill_q != FILL_MAX) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : seq_det_history

`default_nettype wire

// File: rtl/sequence_detector.sv
// ============================================================================
// Module   : sequence_detector
// Brief    : Serial pattern detector with registered match pulse.
//            Optional SEQ_DET_MATCH_COUNT_EN adds a saturating match counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sequence_detector
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(DEFAULT_PATTERN),
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  output logic       found
`ifdef SEQ_DET_MATCH_COUNT_EN
  ,
  output match_cnt_t match_count
`endif
);

  if (PATTERN_LEN < 2 || PATTERN_LEN > 32) begin : g_bad_len
    $fatal(1, "sequence_detector: PATTERN_LEN must be within 2..32");
  end

  logic [PATTERN_LEN-1:0] candidate_w;
  logic                   valid_w;
  logic                   match_w;
  logic                   restart_w;
  logic                   found_q;

  assign match_w   = valid_w && (candidate_w == PATTERN);
  assign restart_w = !OVERLAP && match_w;

  seq_det_history #(
    .PATTERN_LEN (PATTERN_LEN)
  ) u_history (
    .clk         (clk),
    .reset       (reset),
    .in_bit_i    (in_bit),
    .restart_i   (restart_w),
    .candidate_o (candidate_w),
    .valid_o     (valid_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      found_q <= 1'b0;
    end else begin
      found_q <= match_w;
    end
  end

  assign found = found_q;

`ifdef SEQ_DET_MATCH_COUNT_EN
  match_cnt_t match_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_count_q <= '0;
    end else if (match_w && (match_count_q != MATCH_CNT_MAX)) begin
      match_count_q <= match_count_q + 1'b1;
    end
  end

  assign match_count = match_count_q;
`endif

endmodule : sequence_detector

`default_nettype wire

// File: tb/tb_sequence_detector.sv
// ============================================================================
// Module   : tb_sequence_detector
// Brief    : Scoreboard bench over four detector configurations on one stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sequence_detector;
  import seq_det_pkg::*;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       in_bit = 1'b0;
  logic [3:0] found;
`ifdef SEQ_DET_MATCH_COUNT_EN
  match_cnt_t mc0, mc1, mc2, mc3;
`endif

  typedef struct packed {
    logic [3:0]  f;
    logic [15:0] mc0;
    logic [15:0] mc3;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_chk;
  int         nb[4];
  logic [2:0] sh[4];
  match_cnt_t cnt[4];
  int         pulses[4];
  int         checks  = 0;
  int         errors  = 0;
  bit         preset_req = 1'b0;

  always #5 clk = ~clk;

  // 0: "101" overlap, 1: "101" no overlap, 2: "001", 3: "111"
  sequence_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1)) u_def (
    .clk(clk), .reset(reset), .in_bit(in_bit), .found(found[0])
`ifdef SEQ_DET_MATCH_COUNT_EN
    , .match_count(mc0)
`endif
  );
  sequence_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .in_bit(in_bit), .found(found[1])
`ifdef SEQ_DET_MATCH_COUNT_EN
    , .match_count(mc1)
`endif
  );
  sequence_detector #(.PATTERN_LEN(3), .PATTERN(3'b001), .OVERLAP(1'b1)) u_001 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .found(found[2])
`ifdef SEQ_DET_MATCH_COUNT_EN
    , .match_count(mc2)
`endif
  );
  sequence_detector #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u_111 (
    .clk(clk), .reset(reset), .in_bit(in_bit), .found(found[3])
`ifdef SEQ_DET_MATCH_COUNT_EN
    , .match_count(mc3)
`endif
  );

  function automatic logic [2:0] pat(input int i);
    case (i)
      2:       return 3'b001;
      3:       return 3'b111;
      default: return 3'b101;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b);
    exp_t e;
    @(negedge clk);
    reset  = r;
    in_bit = b;
`ifdef SEQ_DET_MATCH_COUNT_EN
    if (preset_req) begin
      u_111.match_count_q = 16'hFFFD;
      cnt[3]     = 16'hFFFD;
      preset_req = 1'b0;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        nb[i]  = 0;
        sh[i]  = 3'b000;
        cnt[i] = '0;
        e.f[i] = 1'b0;
      end else begin
        sh[i]  = {sh[i][1:0], b};
        nb[i]  = nb[i] + 1;
        e.f[i] = (nb[i] >= 3) && (sh[i] == pat(i));
        if (e.f[i]) begin
          if (cnt[i] != 16'hFFFF) cnt[i] = cnt[i] + 1'b1;
          if (i == 1) nb[i] = 0;
        end
      end
    end
    e.mc0 = cnt[0];
    e.mc3 = cnt[3];
    exp_q.push_back(e);
  endtask

  task automatic stream(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_chk = exp_q.pop_front();
      check("found_101_ovl", {31'd0, found[0]}, {31'd0, e_chk.f[0]});
      check("found_101_novl", {31'd0, found[1]}, {31'd0, e_chk.f[1]});
      check("found_001", {31'd0, found[2]}, {31'd0, e_chk.f[2]});
      check("found_111", {31'd0, found[3]}, {31'd0, e_chk.f[3]});
      for (int i = 0; i < 4; i++) if (found[i] === 1'b1) pulses[i]++;
`ifdef SEQ_DET_MATCH_COUNT_EN
      check("match_count_101", {16'd0, mc0}, {16'd0, e_chk.mc0});
      check("match_count_111", {16'd0, mc3}, {16'd0, e_chk.mc3});
`endif
    end
  end

  initial begin
    // reset with in_bit high, then 1 0 1 and two trailing zeros
    step(1'b1, 1'b1);
    stream(32'b101, 3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    clear_pulses();
    stream(32'b10101101, 8);
    step(1'b0, 1'b0);
    check("pulses_101_stream8", pulses[0], 3);

    step(1'b1, 1'b0);
    clear_pulses();
    stream(32'b10101, 5);
    step(1'b0, 1'b0);
    check("pulses_101_ovl_stream5", pulses[0], 2);
    check("pulses_101_novl_stream5", pulses[1], 1);

    // leading-zero pattern must not match reset history
    step(1'b1, 1'b0);
    clear_pulses();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    stream(32'b001, 3);
    step(1'b0, 1'b0);
    check("pulses_001", pulses[2], 1);

    // reset in the middle of 1 0 ... 1
    step(1'b1, 1'b0);
    clear_pulses();
    stream(32'b10, 2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pulses_101_after_midreset", pulses[0], 0);

    step(1'b1, 1'b0);
    clear_pulses();
    stream(32'b11111, 5);
    step(1'b0, 1'b0);
    check("pulses_111_backtoback", pulses[3], 3);

`ifdef SEQ_DET_MATCH_COUNT_EN
    step(1'b1, 1'b0);
    stream(32'b10101101, 8);
    step(1'b0, 1'b0);
    check("match_count_stream8", {16'd0, mc0}, 32'd3);
    preset_req = 1'b1;
    stream(32'b111111, 6);
    step(1'b0, 1'b0);
    check("match_count_saturated", {16'd0, mc3}, 32'h0000FFFF);
`endif

    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sequence_detector

`default_nettype wire
